// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: framer state
// encoding, parity mode codes and the word-length clamp helper.
package uart_pkg;

  // Framer states; PARITY is only reachable when parity support is built
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned MIN_BITS = 5;

  // Limits a requested word length to the range MIN_BITS..max_bits
  function automatic logic [4:0] clamp_bits(input logic [3:0] req,
                                            input int unsigned max_bits);
    int unsigned r;
    r = {28'd0, req};
    if (r < MIN_BITS) r = MIN_BITS;
    if (r > max_bits) r = max_bits;
    return r[4:0];
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Register-file facing bundle of the buffered UART transmitter: enqueue
// port, frame configuration and the status/serial outputs.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 32,
  parameter int DIV_WIDTH  = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  flush;
  logic [3:0]            cfg_bits;
  logic [1:0]            cfg_parity;
  logic                  cfg_stop2;
  logic [DIV_WIDTH-1:0]  clk_div;

  logic                  tx;
  logic                  busy;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_count;
  logic                  overflow;

  modport master (
    output wr_data, wr_en, flush, cfg_bits, cfg_parity, cfg_stop2, clk_div,
    input  tx, busy, fifo_empty, fifo_full, fifo_count, overflow
  );

  modport slave (
    input  wr_data, wr_en, flush, cfg_bits, cfg_parity, cfg_stop2, clk_div,
    output tx, busy, fifo_empty, fifo_full, fifo_count, overflow
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count, flush and
// a sticky overflow flag for writes dropped while full.
module sync_fifo #(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush_i,
  input  logic                            wr_en_i,
  input  logic [DATA_WIDTH-1:0]           wr_data_i,
  input  logic                            rd_en_i,
  output logic [DATA_WIDTH-1:0]           rd_data_o,
  output logic [$clog2(FIFO_DEPTH):0]     count_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic                            overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  overflow_q;
  logic                  full;
  logic                  empty;
  logic                  do_wr;
  logic                  do_rd;

  // A full FIFO still accepts a write when the head leaves in the same cycle;
  // flush discards everything, including a coincident write
  always_comb begin
    full    = (count_q == CNT_W'(FIFO_DEPTH));
    empty   = (count_q == '0);
    do_rd   = rd_en_i && !empty;
    do_wr   = wr_en_i && (!full || do_rd) && !flush_i;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because the count gates reads
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers and occupancy, cleared by reset or flush
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Sticky record of a dropped write; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (wr_en_i && full && !do_rd && !flush_i) begin
      overflow_q <= 1'b1;
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FWFT FIFO feeding a framer that sends
// start, 5..DATA_WIDTH data bits LSB first, optional parity and 1 or 2 stop
// bits. Frame settings are captured when a word is popped, so register
// writes during a frame only affect later frames.
// Build option: define UART_TX_PARITY_EN to include the parity bit logic;
// without it cfg_parity is ignored and all frames are unparitied.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 32,
  parameter int DIV_WIDTH  = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  logic [DATA_WIDTH-1:0]         fifo_rd_data;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          fifo_overflow;
  logic                          pop;
  logic                          bit_end;
  logic [4:0]                    load_bits;

  state_e                        state_q;
  logic [DATA_WIDTH-1:0]         shift_q;
  logic [4:0]                    bits_q;
  logic [4:0]                    bit_idx_q;
  logic [DIV_WIDTH-1:0]          div_q;
  logic [DIV_WIDTH-1:0]          timer_q;
  logic                          stop2_q;
  logic                          stop_idx_q;
  logic                          tx_q;
  logic                          busy_q;

`ifdef UART_TX_PARITY_EN
  logic [DATA_WIDTH-1:0]         load_mask;
  logic                          par_en_q;
  logic                          par_bit_q;
`else
  logic                          unused_cfg_parity;
  assign unused_cfg_parity = ^bus.cfg_parity;
`endif

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (bus.flush),
    .wr_en_i    (bus.wr_en),
    .wr_data_i  (bus.wr_data),
    .rd_en_i    (pop),
    .rd_data_o  (fifo_rd_data),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_overflow)
  );

  // A word is taken either from idle or at the very end of the last stop
  // bit, which lets consecutive frames run with no idle gap
  always_comb begin
    bit_end   = (timer_q == div_q);
    load_bits = clamp_bits(bus.cfg_bits, DATA_WIDTH);
    pop       = !fifo_empty &&
                ((state_q == IDLE) ||
                 (state_q == STOP && bit_end && (stop_idx_q == stop2_q)));
  end

`ifdef UART_TX_PARITY_EN
  // Selects the data bits that will actually be sent, for the parity sum
  always_comb begin
    load_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      load_mask[i] = (i < int'(load_bits));
    end
  end
`endif

  // Framer state machine with registered line and busy outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bits_q     <= 5'(MIN_BITS);
      bit_idx_q  <= '0;
      div_q      <= '0;
      timer_q    <= '0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else if (pop) begin
      state_q    <= START;
      shift_q    <= fifo_rd_data;
      bits_q     <= load_bits;
      div_q      <= bus.clk_div;
      stop2_q    <= bus.cfg_stop2;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b0;
      busy_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= (bus.cfg_parity == PAR_EVEN) || (bus.cfg_parity == PAR_ODD);
      par_bit_q  <= (^(fifo_rd_data & load_mask)) ^ (bus.cfg_parity == PAR_ODD);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            timer_q   <= '0;
            state_q   <= DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer_q <= '0;
            if (bit_idx_q == bits_q - 5'd1) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q    <= STOP;
                tx_q       <= 1'b1;
                stop_idx_q <= 1'b0;
              end
`else
              state_q    <= STOP;
              tx_q       <= 1'b1;
              stop_idx_q <= 1'b0;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 5'd1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            timer_q    <= '0;
            state_q    <= STOP;
            tx_q       <= 1'b1;
            stop_idx_q <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            timer_q <= '0;
            if (stop_idx_q != stop2_q) begin
              stop_idx_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_empty = fifo_empty;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = fifo_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frame vectors, bursts,
// FIFO full/overflow, reset and flush sequences, and random bursts checked
// against a frame-level reference model.
module tb_uart_tx_fifo;

  localparam int DW    = 9;
  localparam int DEPTH = 32;
  localparam int DIVW  = 16;
  localparam int CNTW  = $clog2(DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_tx_fifo_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) bus ();

  uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  word;
    logic [3:0]  bits;
    logic [1:0]  par;
    logic        stop2;
    logic [15:0] div;
    int          nbits;
    int          parBit;
    int          cfgAt;
    logic [3:0]  newBits;
    int          len;
  } vec_t;

  vec_t       vecs [8];
  int         nCompared   = 0;
  int         nMismatched = 0;
  logic [8:0] burstWord  [4];
  int         burstNbits [4];
  int         burstPar   [4];
  int         busyCycles;

  // Reference: effective word length after clamping to 5..DW
  function automatic int modelNbits(input int cfgBits);
    int b;
    b = (cfgBits < 5) ? 5 : cfgBits;
    if (b > DW) b = DW;
    return b;
  endfunction

  // Reference: parity bit value, or 2 when no parity bit is sent
  function automatic int modelParity(input logic [8:0] w, input int nb, input logic [1:0] mode);
    int ones;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(w[i]);
    if (!PAR_BUILT) return 2;
    if (mode == 2'b01) return ones % 2;
    if (mode == 2'b10) return 1 - (ones % 2);
    return 2;
  endfunction

  task automatic setVec(input int i, input logic [8:0] word, input logic [3:0] bits,
                        input logic [1:0] par, input logic stop2, input logic [15:0] div,
                        input int nbits, input int parBit, input int cfgAt,
                        input logic [3:0] newBits, input int len);
    vecs[i].word = word;   vecs[i].bits = bits;   vecs[i].par = par;
    vecs[i].stop2 = stop2; vecs[i].div = div;     vecs[i].nbits = nbits;
    vecs[i].parBit = parBit; vecs[i].cfgAt = cfgAt; vecs[i].newBits = newBits;
    vecs[i].len = len;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Writes n words on consecutive cycles into an empty idle DUT and checks
  // the line cycle by cycle against the first nExp frames of the model.
  task automatic applyStimulus(input int n, input int nExp, input int flushAt,
                               input int cfgAt, input logic [3:0] newBits, input string tag);
    logic       expQ [$];
    logic [3:0] oldBits;
    int         per;
    int         bad;
    per = int'(bus.clk_div) + 1;
    for (int k = 0; k < nExp; k++) begin
      logic fb [$];
      fb = {};
      fb.push_back(1'b0);
      for (int i = 0; i < burstNbits[k]; i++) fb.push_back(burstWord[k][i]);
      if (burstPar[k] != 2) fb.push_back(burstPar[k][0]);
      fb.push_back(1'b1);
      if (bus.cfg_stop2) fb.push_back(1'b1);
      foreach (fb[j]) for (int r = 0; r < per; r++) expQ.push_back(fb[j]);
    end
    oldBits = bus.cfg_bits;
    bus.wr_data = burstWord[0];
    bus.wr_en   = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, " count/tx after write"}, {bus.fifo_count, bus.tx}, {6'd1, 1'b1});
    bad = 0;
    busyCycles = 0;
    for (int t = 1; t <= expQ.size(); t++) begin
      if (t < n) begin
        bus.wr_data = burstWord[t];
        bus.wr_en   = 1'b1;
      end else begin
        bus.wr_en = 1'b0;
      end
      bus.flush = (t == flushAt);
      if (t == cfgAt) bus.cfg_bits = newBits;
      @(posedge clk); #1;
      if (bus.busy === 1'b1) busyCycles++;
      if (bus.tx !== expQ[t-1] || bus.busy !== 1'b1) bad++;
    end
    bus.wr_en    = 1'b0;
    bus.flush    = 1'b0;
    bus.cfg_bits = oldBits;
    checkOutput({tag, " frame bad cycles"}, bad, 0);
    @(posedge clk); #1;
    checkOutput({tag, " idle tx/busy/empty"}, {bus.tx, bus.busy, bus.fifo_empty}, 3'b101);
  endtask

  initial begin
    logic prevTx;
    bit   found;
    int   n;

    rst = 1'b1;
    bus.wr_en = 1'b0;      bus.flush = 1'b0;     bus.wr_data = '0;
    bus.cfg_bits = 4'd8;   bus.cfg_parity = 2'b00;
    bus.cfg_stop2 = 1'b0;  bus.clk_div = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state",
                {bus.tx, bus.busy, bus.fifo_empty, bus.fifo_full, bus.overflow, bus.fifo_count},
                {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0});
    rst = 1'b0;

    setVec(0, 9'h0A5,  4'd8, 2'b00, 1'b0, 16'd3, 8, 2,                -1, 4'd0, 40);
    setVec(1, 9'h1FF,  4'd9, 2'b01, 1'b0, 16'd0, 9, PAR_BUILT ? 1 : 2, -1, 4'd0, PAR_BUILT ? 12 : 11);
    setVec(2, 9'h1FF,  4'd9, 2'b10, 1'b0, 16'd0, 9, PAR_BUILT ? 0 : 2, -1, 4'd0, PAR_BUILT ? 12 : 11);
    setVec(3, 9'h013,  4'd2, 2'b00, 1'b0, 16'd1, 5, 2,                -1, 4'd0, 14);
    setVec(4, 9'h155, 4'd15, 2'b11, 1'b1, 16'd0, 9, 2,                -1, 4'd0, 12);
    setVec(5, 9'h0F0,  4'd8, 2'b01, 1'b1, 16'd2, 8, PAR_BUILT ? 0 : 2, -1, 4'd0, PAR_BUILT ? 36 : 33);
    setVec(6, 9'h1A7,  4'd7, 2'b10, 1'b0, 16'd0, 7, PAR_BUILT ? 1 : 2, -1, 4'd0, PAR_BUILT ? 10 : 9);
    setVec(7, 9'h0C3,  4'd8, 2'b00, 1'b0, 16'd1, 8, 2,                 3, 4'd5, 20);

    for (int i = 0; i < 8; i++) begin
      bus.cfg_bits   = vecs[i].bits;
      bus.cfg_parity = vecs[i].par;
      bus.cfg_stop2  = vecs[i].stop2;
      bus.clk_div    = vecs[i].div;
      burstWord[0]   = vecs[i].word;
      burstNbits[0]  = vecs[i].nbits;
      burstPar[0]    = vecs[i].parBit;
      applyStimulus(1, 1, -1, vecs[i].cfgAt, vecs[i].newBits, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d busy length", i), busyCycles, vecs[i].len);
    end

    // Three words back to back with two stop bits
    bus.cfg_bits = 4'd8; bus.cfg_parity = 2'b00; bus.cfg_stop2 = 1'b1; bus.clk_div = 16'd1;
    for (int k = 0; k < 3; k++) begin
      burstWord[k]  = 9'($urandom);
      burstNbits[k] = 8;
      burstPar[k]   = 2;
    end
    applyStimulus(3, 3, -1, -1, 4'd0, "b2b");
    checkOutput("b2b busy length", busyCycles, 66);

    // Random bursts against the reference model
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 3);
      bus.cfg_bits   = 4'($urandom_range(0, 15));
      bus.cfg_parity = 2'($urandom_range(0, 3));
      bus.cfg_stop2  = 1'($urandom_range(0, 1));
      bus.clk_div    = 16'($urandom_range(0, 3));
      for (int k = 0; k < n; k++) begin
        burstWord[k]  = 9'($urandom);
        burstNbits[k] = modelNbits(int'(bus.cfg_bits));
        burstPar[k]   = modelParity(burstWord[k], burstNbits[k], bus.cfg_parity);
      end
      applyStimulus(n, n, -1, -1, 4'd0, $sformatf("rand%0d", it));
    end

    // Fill the FIFO behind a slow all-ones frame, then overflow it
    bus.cfg_bits = 4'd8; bus.cfg_parity = 2'b00; bus.cfg_stop2 = 1'b0; bus.clk_div = 16'd99;
    bus.wr_data = 9'h0FF;
    bus.wr_en   = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    checkOutput("fill count", bus.fifo_count, 32);
    checkOutput("fill full", bus.fifo_full, 1'b1);
    checkOutput("fill no overflow", bus.overflow, 1'b0);
    @(posedge clk); #1;
    checkOutput("overflow set", bus.overflow, 1'b1);
    checkOutput("count after drop", bus.fifo_count, 32);
    found = 1'b0;
    for (int c = 0; c < 1200 && !found; c++) begin
      prevTx = bus.tx;
      @(posedge clk); #1;
      if (prevTx === 1'b1 && bus.tx === 1'b0) found = 1'b1;
    end
    checkOutput("pop at full seen", found, 1'b1);
    checkOutput("write+pop at full count", bus.fifo_count, 32);
    checkOutput("overflow sticky", bus.overflow, 1'b1);
    bus.wr_en = 1'b0;

    // Reset in the middle of the data bits
    repeat (150) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("reset mid-frame",
                {bus.tx, bus.busy, bus.overflow, bus.fifo_full, bus.fifo_count},
                {1'b1, 1'b0, 1'b0, 1'b0, 6'd0});

    // Flush while the first frame is on the line: it completes, rest dropped
    bus.cfg_bits = 4'd8; bus.cfg_parity = 2'b00; bus.cfg_stop2 = 1'b0; bus.clk_div = 16'd1;
    for (int k = 0; k < 3; k++) begin
      burstWord[k]  = 9'($urandom);
      burstNbits[k] = 8;
      burstPar[k]   = 2;
    end
    applyStimulus(3, 1, 5, -1, 4'd0, "flush");
    checkOutput("flush busy length", busyCycles, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised, buffered UART transmitter and successor to the fixed 8-bit TX + FIFO pair hung off the GPMC register file. It combines a synchronous FIFO of configurable depth and width with a TX framer that supports runtime word length, optional parity, 1 or 2 stop bits, sticky overflow and FIFO flush. Register-file bits drive it directly; status outputs return to the register file.

Parameters:
DATA_WIDTH, 9, max bits per word and FIFO word width (≥5)
FIFO_DEPTH, 32, FIFO entries (power of two, ≥2)
DIV_WIDTH, 16, width of clk_div

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wr_data  in  DATA_WIDTH  word to enqueue; LSB transmitted first
wr_en  in  1  enqueue strobe, one word per cycle high
flush  in  1  synchronous FIFO clear; does not abort current frame
cfg_bits  in  4  bits per word; clamped to 5..DATA_WIDTH
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  in  1  0 one stop bit, 1 two stop bits
clk_div  in  DIV_WIDTH  bit period = clk_div+1 clk cycles
tx  out  1  serial line, idle high
busy  out  1  frame in progress
fifo_empty  out  1  FIFO holds 0 words
fifo_full  out  1  FIFO holds FIFO_DEPTH words
fifo_count  out  $clog2(FIFO_DEPTH)+1  words stored
overflow  out  1  sticky: write dropped while full

Behaviour:
- Reset (clk edge with rst=1): tx=1, busy=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0, FSM=IDLE, pointers=0. Mid-frame reset aborts the frame; tx=1 from the next cycle.
- FIFO: first-word-fall-through head. Write is accepted if !full, or if full with a same-cycle pop. Write+pop together leaves the count unchanged. A write while full with no pop is dropped and sets overflow. overflow clears only on rst.
- flush: empties the FIFO and zeroes the count. flush wins over a same-cycle write. The in-flight frame completes.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when !fifo_empty, pop the head into the shift register and latch cfg_bits (clamped), cfg_parity, cfg_stop2 and clk_div. Go to START with busy=1. Config changes mid-frame have no effect.
- Latency: wr_en at edge N into an empty FIFO with FSM idle gives count=1 after N, pop at N+1, tx=0 after N+1.
- Bit timer: counts 0..div_latched; each bit lasts div_latched+1 cycles. clk_div=0 gives 1 cycle per bit.
- DATA: shifts out the latched bit count, LSB first; upper unused bits are ignored.
- PARITY: entered only for modes 01/10. The bit is the XOR of the transmitted data bits (even), or its inverse (odd).
- STOP: tx=1 for 1 or 2 bit periods.
- End of STOP:
  - FIFO non-empty: pop immediately; the next START begins the following cycle (back-to-back, no idle gap); busy stays 1.
  - Otherwise: IDLE, busy=0.
- Frame length in cycles: (1 + bits + parity + stop) × (div+1).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: parity behaviour as above.
- Undefined: the PARITY state and parity logic are not built; cfg_parity is ignored and every frame is unparitied.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/PARITY/STOP)
  - parity codes PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10
  - MIN_BITS=5
- Sub-module sync_fifo (parametrised DATA_WIDTH/FIFO_DEPTH, FWFT, count/full/empty, flush), instantiated once. The framer FSM lives in uart_tx_fifo.

Test Plan:
- Reset then write 8'hA5, bits=8, parity none, stop1, div=3 -> tx low 4 cycles after the pop, then 1,0,1,0,0,1,0,1, then high; each bit 4 cycles; busy spans 40 cycles.
- Write 9'h1FF, bits=9, parity even, div=0 -> frame 0,1×9, parity 1, stop 1. With odd parity -> parity bit 0. With UART_TX_PARITY_EN undefined -> no parity bit.
- Write 3 words back-to-back, stop2, div=1 -> stop of word k is followed immediately by start of word k+1; busy stays 1 throughout; fifo_empty rises after the third pop.
- Fill 32 words while tx stalled (div=max) -> fifo_full=1, count=32. A 33rd write sets overflow=1 and count stays 32. Write+pop in the same cycle at full -> accepted, count 32.
- cfg_bits=2 -> 5 bits sent; cfg_bits=15 -> DATA_WIDTH bits sent. Changing cfg_bits mid-frame leaves the current frame unchanged.
- Assert rst during the DATA state -> tx=1 and busy=0 next cycle, count=0, overflow=0. flush mid-frame -> current frame completes, then IDLE.
